// File: rtl/alu_op_sequencer.sv
// Initiator for the packed ALU pad interface: issues {sel,B,A}, waits a fixed settling
// time, samples the packed result byte and returns Y/Cout with error flag and counters.
module alu_op_sequencer #(
  parameter int unsigned WAIT_CYC = 2,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_a,
  input  logic [2:0]       cmd_b,
  input  logic [1:0]       cmd_sel,
  output logic [7:0]       op_byte,
  input  logic [7:0]       res_byte,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [2:0]       rsp_y,
  output logic             rsp_cout,
  output logic             rsp_err,
  output logic [CNT_W-1:0] op_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int unsigned WCNT_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  logic [WCNT_W-1:0] wait_cnt;
  logic              res_err_c;

  // Any set reserved bit (7:5 or 3) marks the result as malformed
  assign res_err_c = (|res_byte[7:5]) | res_byte[3];
  assign cmd_ready = (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      op_byte   <= '0;
      rsp_valid <= 1'b0;
      rsp_y     <= '0;
      rsp_cout  <= 1'b0;
      rsp_err   <= 1'b0;
      op_count  <= '0;
      err_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_byte  <= {cmd_sel, cmd_b, cmd_a};
            wait_cnt <= WCNT_W'(WAIT_CYC - 1);
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - WCNT_W'(1);
          end else begin
            // Sample edge: res_byte is looked at only here
            rsp_y     <= res_byte[2:0];
            rsp_cout  <= res_byte[4];
            rsp_err   <= res_err_c;
            rsp_valid <= 1'b1;
            if (op_count != '1) op_count <= op_count + CNT_W'(1);
            if (res_err_c && (err_count != '1)) err_count <= err_count + CNT_W'(1);
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized self-checking bench for alu_op_sequencer: dut0 (WAIT_CYC=2, CNT_W=8) and
// dut1 (WAIT_CYC=1, CNT_W=2) against a transaction-level model of the result decoding.
module tb_alu_op_sequencer;

  logic       clk;
  logic       rst;
  logic       cmd_valid [2];
  logic       cmd_ready [2];
  logic [2:0] cmd_a     [2];
  logic [2:0] cmd_b     [2];
  logic [1:0] cmd_sel   [2];
  logic [7:0] op_byte   [2];
  logic [7:0] res_byte  [2];
  logic       rsp_valid [2];
  logic       rsp_ready [2];
  logic [2:0] rsp_y     [2];
  logic       rsp_cout  [2];
  logic       rsp_err   [2];
  logic [7:0] op_count0, err_count0;
  logic [1:0] op_count1, err_count1;

  int n_chk  = 0;
  int n_pass = 0;
  int n_ops  [2];
  int n_errs [2];

  alu_op_sequencer #(.WAIT_CYC(2), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_a(cmd_a[0]), .cmd_b(cmd_b[0]), .cmd_sel(cmd_sel[0]), .op_byte(op_byte[0]),
    .res_byte(res_byte[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_y(rsp_y[0]), .rsp_cout(rsp_cout[0]), .rsp_err(rsp_err[0]),
    .op_count(op_count0), .err_count(err_count0)
  );

  alu_op_sequencer #(.WAIT_CYC(1), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_a(cmd_a[1]), .cmd_b(cmd_b[1]), .cmd_sel(cmd_sel[1]), .op_byte(op_byte[1]),
    .res_byte(res_byte[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_y(rsp_y[1]), .rsp_cout(rsp_cout[1]), .rsp_err(rsp_err[1]),
    .op_count(op_count1), .err_count(err_count1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] get_opc(input int d);
    return (d == 0) ? op_count0 : {6'b0, op_count1};
  endfunction

  function automatic logic [7:0] get_erc(input int d);
    return (d == 0) ? err_count0 : {6'b0, err_count1};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      cmd_valid[d] = 1'b0; rsp_ready[d] = 1'b0; cmd_a[d] = '0; cmd_b[d] = '0;
      cmd_sel[d] = '0; res_byte[d] = '0; n_ops[d] = 0; n_errs[d] = 0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if ({cmd_ready[d], rsp_valid[d], op_byte[d], rsp_y[d], rsp_cout[d], rsp_err[d],
           get_opc(d), get_erc(d)} !== {1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 8'h00, 8'h00})
        $display("FAIL reset_state dut%0d: ready=%b valid=%b op=%h y=%0d c=%b e=%b oc=%0d ec=%0d, want ready=1 rest 0",
                 d, cmd_ready[d], rsp_valid[d], op_byte[d], rsp_y[d], rsp_cout[d], rsp_err[d],
                 get_opc(d), get_erc(d));
      else n_pass++;
    end
  endtask

  // One full transaction on dut d; entered and left at a negedge.
  task automatic run_op(input int d, input logic [2:0] a, input logic [2:0] b,
                        input logic [1:0] sel, input logic [7:0] res,
                        input int stall, input bit hold);
    int         w     = (d == 0) ? 2 : 1;
    int         maxc  = (d == 0) ? 255 : 3;
    logic [7:0] exp_ob = {sel, b, a};
    logic [2:0] ey    = 3'(res % 8);
    logic       ec    = res[4];
    logic       ee    = (res & 8'hE8) != 8'h00;
    int         eoc, eec;
    cmd_a[d] = a; cmd_b[d] = b; cmd_sel[d] = sel; cmd_valid[d] = 1'b1; rsp_ready[d] = 1'b0;
    n_chk++;
    if (cmd_ready[d] !== 1'b1) $display("FAIL ready_before_accept dut%0d: got %b want 1", d, cmd_ready[d]);
    else n_pass++;
    @(posedge clk); @(negedge clk);
    n_chk++;
    if (op_byte[d] !== exp_ob || cmd_ready[d] !== 1'b0)
      $display("FAIL accept dut%0d: op_byte=%h ready=%b want %h 0", d, op_byte[d], cmd_ready[d], exp_ob);
    else n_pass++;
    cmd_valid[d] = hold;
    cmd_a[d] = 3'($urandom); cmd_b[d] = 3'($urandom); cmd_sel[d] = 2'($urandom);
    for (int i = 1; i <= w; i++) begin
      res_byte[d] = (i == w) ? res : 8'($urandom);
      n_chk++;
      if (rsp_valid[d] !== 1'b0) $display("FAIL early_valid dut%0d step %0d: got %b want 0", d, i, rsp_valid[d]);
      else n_pass++;
      @(posedge clk); @(negedge clk);
    end
    n_ops[d]++;
    if (ee) n_errs[d]++;
    eoc = (n_ops[d] > maxc) ? maxc : n_ops[d];
    eec = (n_errs[d] > maxc) ? maxc : n_errs[d];
    n_chk++;
    if ({rsp_valid[d], rsp_y[d], rsp_cout[d], rsp_err[d]} !== {1'b1, ey, ec, ee})
      $display("FAIL response dut%0d res=%h: valid=%b y=%0d c=%b e=%b want 1 %0d %b %b",
               d, res, rsp_valid[d], rsp_y[d], rsp_cout[d], rsp_err[d], ey, ec, ee);
    else n_pass++;
    n_chk++;
    if (get_opc(d) !== 8'(eoc) || get_erc(d) !== 8'(eec))
      $display("FAIL counters dut%0d: op=%0d err=%0d want %0d %0d", d, get_opc(d), get_erc(d), eoc, eec);
    else n_pass++;
    for (int j = 0; j < stall; j++) begin
      res_byte[d] = 8'($urandom);
      @(posedge clk); @(negedge clk);
      n_chk++;
      if ({rsp_valid[d], rsp_y[d], rsp_cout[d], rsp_err[d], cmd_ready[d], op_byte[d]} !==
          {1'b1, ey, ec, ee, 1'b0, exp_ob})
        $display("FAIL stall_hold dut%0d cyc %0d: valid=%b y=%0d c=%b e=%b ready=%b op=%h want 1 %0d %b %b 0 %h",
                 d, j, rsp_valid[d], rsp_y[d], rsp_cout[d], rsp_err[d], cmd_ready[d], op_byte[d],
                 ey, ec, ee, exp_ob);
      else n_pass++;
    end
    rsp_ready[d] = 1'b1;
    @(posedge clk); @(negedge clk);
    rsp_ready[d] = 1'b0;
    n_chk++;
    if ({rsp_valid[d], cmd_ready[d], rsp_y[d], rsp_cout[d], rsp_err[d], op_byte[d]} !==
        {1'b0, 1'b1, ey, ec, ee, exp_ob})
      $display("FAIL handshake dut%0d: valid=%b ready=%b y=%0d c=%b e=%b op=%h want 0 1 %0d %b %b %h",
               d, rsp_valid[d], cmd_ready[d], rsp_y[d], rsp_cout[d], rsp_err[d], op_byte[d],
               ey, ec, ee, exp_ob);
    else n_pass++;
  endtask

  task automatic test_reset_mid_op();
    cmd_a[0] = 3'd1; cmd_b[0] = 3'd2; cmd_sel[0] = 2'd1; cmd_valid[0] = 1'b1;
    @(posedge clk); @(negedge clk);
    cmd_valid[0] = 1'b0;
    rst = 1'b1;
    #1;
    n_chk++;
    if ({rsp_valid[0], op_byte[0], op_count0, err_count0} !== {1'b0, 8'h00, 8'h00, 8'h00})
      $display("FAIL async_reset: valid=%b op=%h oc=%0d ec=%0d want all 0",
               rsp_valid[0], op_byte[0], op_count0, err_count0);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    n_ops[0] = 0; n_errs[0] = 0; n_ops[1] = 0; n_errs[1] = 0;
    @(negedge clk);
    n_chk++;
    if (cmd_ready[0] !== 1'b1) $display("FAIL ready_after_reset: got %b want 1", cmd_ready[0]);
    else n_pass++;
    repeat (3) begin
      @(negedge clk);
      n_chk++;
      if (rsp_valid[0] !== 1'b0 || op_count0 !== 8'h00)
        $display("FAIL no_rsp_after_reset: valid=%b oc=%0d want 0 0", rsp_valid[0], op_count0);
      else n_pass++;
    end
  endtask

  task automatic test_basic();
    run_op(0, 3'd3, 3'd5, 2'd0, 8'h10, 0, 1'b0);
    n_chk++;
    if (op_byte[0] !== 8'h2B) $display("FAIL basic_op_byte: got %h want 2B", op_byte[0]);
    else n_pass++;
  endtask

  task automatic test_reserved();
    run_op(0, 3'd2, 3'd6, 2'd2, 8'h0C, 1, 1'b0);
    run_op(0, 3'd4, 3'd1, 2'd3, 8'h80, 0, 1'b0);
    n_chk++;
    if (err_count0 !== 8'd2) $display("FAIL reserved_err_count: got %0d want 2", err_count0);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    run_op(0, 3'd6, 3'd3, 2'd1, 8'h15, 5, 1'b1);
    run_op(0, 3'($urandom), 3'($urandom), 2'($urandom), 8'($urandom), 2, 1'b0);
  endtask

  task automatic test_random(input int d, input int n);
    for (int i = 0; i < n; i++)
      run_op(d, 3'($urandom), 3'($urandom), 2'($urandom),
             ($urandom_range(0, 1) == 1) ? 8'($urandom) : {3'b0, 1'($urandom), 1'b0, 3'($urandom)},
             int'($urandom_range(0, 3)), 1'($urandom));
    cmd_valid[d] = 1'b0;
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) run_op(1, 3'($urandom), 3'($urandom), 2'($urandom), 8'h08, 0, 1'b0);
    n_chk++;
    if (op_count1 !== 2'd3 || err_count1 !== 2'd3)
      $display("FAIL saturation: op=%0d err=%0d want 3 3", op_count1, err_count1);
    else n_pass++;
  endtask

  task automatic test_min_latency();
    run_op(1, 3'd7, 3'd7, 2'd3, 8'h17, 0, 1'b0);
    n_chk++;
    if (op_byte[1] !== 8'hFF) $display("FAIL min_latency_op_byte: got %h want FF", op_byte[1]);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_reset_mid_op();
    test_basic();
    test_reserved();
    test_back_to_back();
    test_random(0, 20);
    test_saturation();
    test_min_latency();
    test_random(1, 10);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
